// File: rtl/systolic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | systolic_ctrl: job sequencer for an output-stationary ROWSxCOLS MAC array.   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module systolic_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [KW-1:0]           K_LEN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FEED_REQ,
  input  logic                    FEED_VALID,
  output logic [ROWS-1:0]         ROW_VALID,
  output logic [COLS-1:0]         COL_VALID,
  output logic                    COMPUTE,
  output logic                    FLUSH,
  output logic                    STALL,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [$clog2(ROWS)-1:0] OUT_ROW
);

  localparam int c_TW = KW + 2;
  localparam int c_FW = $clog2(ROWS);
  localparam logic [c_TW-1:0] c_TAIL     = c_TW'(ROWS + COLS - 2);
  localparam logic [c_FW-1:0] c_LAST_ROW = c_FW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [c_TW-1:0] r_t, w_t_nxt;
  logic [c_FW-1:0] r_f, w_f_nxt;
  logic [c_TW-1:0] w_k_ext;

  logic            r_busy, r_done, r_feed_req, r_compute, r_flush, r_out_valid;
  logic [ROWS-1:0] r_row_valid, w_row_nxt;
  logic [COLS-1:0] r_col_valid, w_col_nxt;
  logic [c_FW-1:0] r_out_row;

  logic            w_feed_stall, w_out_stall, w_t_last;
  logic            w_run_nxt, w_flush_nxt;

  // Stall is one gate deep: registered request/valid qualified by this cycle's input.
  assign w_feed_stall = r_feed_req & ~FEED_VALID;
  assign w_out_stall  = r_out_valid & ~OUT_READY;
  assign w_t_last     = (r_t == ({2'b00, r_k} + c_TAIL));

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_t_nxt     = r_t;
    w_f_nxt     = r_f;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          if (K_LEN != '0) begin
            w_state_nxt = S_RUN;
            w_k_nxt     = K_LEN;
            w_t_nxt     = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!w_feed_stall) begin
          if (w_t_last) begin
            w_state_nxt = S_FLUSH;
            w_f_nxt     = '0;
          end else begin
            w_t_nxt = r_t + c_TW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!w_out_stall) begin
          if (r_f == c_LAST_ROW) begin
            w_state_nxt = S_DONE;
          end else begin
            w_f_nxt = r_f + c_FW'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output vectors are decoded from the next state so every output leaves a flop.
  always_comb begin
    w_run_nxt   = (w_state_nxt == S_RUN);
    w_flush_nxt = (w_state_nxt == S_FLUSH);
    w_k_ext     = {2'b00, w_k_nxt};
    w_row_nxt   = '0;
    w_col_nxt   = '0;
    if (w_run_nxt) begin
      for (int i = 0; i < ROWS; i++) begin
        w_row_nxt[i] = (w_t_nxt >= c_TW'(i)) && (w_t_nxt < (c_TW'(i) + w_k_ext));
      end
      for (int j = 0; j < COLS; j++) begin
        w_col_nxt[j] = (w_t_nxt >= c_TW'(j)) && (w_t_nxt < (c_TW'(j) + w_k_ext));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_t         <= '0;
      r_f         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_feed_req  <= 1'b0;
      r_compute   <= 1'b0;
      r_flush     <= 1'b0;
      r_out_valid <= 1'b0;
      r_row_valid <= '0;
      r_col_valid <= '0;
      r_out_row   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_t         <= w_t_nxt;
      r_f         <= w_f_nxt;
      r_busy      <= w_run_nxt | w_flush_nxt;
      r_done      <= (w_state_nxt == S_DONE);
      r_feed_req  <= (|w_row_nxt) | (|w_col_nxt);
      r_compute   <= w_run_nxt;
      r_flush     <= w_flush_nxt;
      r_out_valid <= w_flush_nxt;
      r_row_valid <= w_row_nxt;
      r_col_valid <= w_col_nxt;
      r_out_row   <= w_flush_nxt ? w_f_nxt : '0;
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign FEED_REQ  = r_feed_req;
  assign ROW_VALID = r_row_valid;
  assign COL_VALID = r_col_valid;
  assign COMPUTE   = r_compute;
  assign FLUSH     = r_flush;
  assign STALL     = w_feed_stall | w_out_stall;
  assign OUT_VALID = r_out_valid;
  assign OUT_ROW   = r_out_row;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_systolic_ctrl: directed bench for systolic_ctrl, ROWS=COLS=4.             |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_systolic_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [15:0] K_LEN;
  logic       BUSY, DONE, FEED_REQ, FEED_VALID;
  logic [3:0] ROW_VALID, COL_VALID;
  logic       COMPUTE, FLUSH, STALL, OUT_VALID, OUT_READY;
  logic [1:0] OUT_ROW;

  systolic_ctrl #(.ROWS(4), .COLS(4), .KW(16)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .K_LEN      (K_LEN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .FEED_REQ   (FEED_REQ),
    .FEED_VALID (FEED_VALID),
    .ROW_VALID  (ROW_VALID),
    .COL_VALID  (COL_VALID),
    .COMPUTE    (COMPUTE),
    .FLUSH      (FLUSH),
    .STALL      (STALL),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_ROW    (OUT_ROW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle traces of one job window, cycle 0 = the cycle START is first driven.
  logic [63:0] m_compute, m_flush, m_busy, m_done, m_stall, m_row3, m_feedreq, m_both;
  logic [3:0]  rv_hist [64];
  logic [3:0]  cv_hist [64];
  logic [1:0]  or_hist [64];
  logic [16:0] outs_hist [64];
  logic [15:0] acc_seq;
  int          n_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [16:0] all_outs();
    return {BUSY, DONE, FEED_REQ, ROW_VALID, COL_VALID, COMPUTE, FLUSH, STALL,
            OUT_VALID, OUT_ROW};
  endfunction

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; K_LEN = '0; FEED_VALID = 1'b1; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Enters and leaves #1 after a rising edge; fixed 48-cycle window.
  task automatic run_job(input int k, input int fv_lo, input int fv_hi,
                         input int or_lo, input int or_hi, input int rst_at,
                         input int start2_at, input int start_hold);
    m_compute = '0; m_flush = '0; m_busy = '0; m_done = '0;
    m_stall = '0; m_row3 = '0; m_feedreq = '0; m_both = '0;
    acc_seq = '0; n_acc = 0;
    for (int c = 0; c < 48; c++) begin
      START      = (c == 0) || (c == start2_at) || (c <= start_hold);
      K_LEN      = 16'(k);
      FEED_VALID = !((c >= fv_lo) && (c <= fv_hi));
      OUT_READY  = !((c >= or_lo) && (c <= or_hi));
      RST        = (c == rst_at);
      @(negedge CLK);
      m_compute[c] = COMPUTE;
      m_flush[c]   = FLUSH;
      m_busy[c]    = BUSY;
      m_done[c]    = DONE;
      m_stall[c]   = STALL;
      m_row3[c]    = ROW_VALID[3];
      m_feedreq[c] = FEED_REQ;
      m_both[c]    = COMPUTE & FLUSH;
      rv_hist[c]   = ROW_VALID;
      cv_hist[c]   = COL_VALID;
      or_hist[c]   = OUT_ROW;
      outs_hist[c] = all_outs();
      if (OUT_VALID && OUT_READY && n_acc < 8) begin
        acc_seq = acc_seq | (16'(OUT_ROW) << (2 * n_acc));
        n_acc++;
      end
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    RST   = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge CLK);
    chk("reset_outputs", 64'(all_outs()), 64'h0);
    @(posedge CLK); #1;

    // Unstalled K=8 job.
    run_job(8, -1, -1, -1, -1, -1, -1, -1);
    chk("t1_compute", m_compute, mask(1, 15));
    chk("t1_busy",    m_busy,    mask(1, 19));
    chk("t1_flush",   m_flush,   mask(16, 19));
    chk("t1_done",    m_done,    mask(20, 20));
    chk("t1_stall",   m_stall,   64'h0);
    chk("t1_row3",    m_row3,    mask(4, 11));
    chk("t1_feedreq", m_feedreq, mask(1, 11));
    chk("t1_both",    m_both,    64'h0);
    chk("t1_rows",    64'(acc_seq), 64'hE4);
    chk("t1_nacc",    64'(n_acc), 64'd4);
    chk("t1_col_c2",  64'(cv_hist[2]), 64'h3);
    do_reset();

    // Feeder starvation at cycles 3 and 4.
    run_job(8, 3, 4, -1, -1, -1, -1, -1);
    chk("t2_stall",   m_stall,   mask(3, 4));
    chk("t2_compute", m_compute, mask(1, 17));
    chk("t2_done",    m_done,    mask(22, 22));
    chk("t2_row3",    m_row3,    mask(6, 13));
    chk("t2_rv_c4",   64'(rv_hist[4]), 64'h7);
    chk("t2_rv_c5",   64'(rv_hist[5]), 64'h7);
    chk("t2_cv_c5",   64'(cv_hist[5]), 64'h7);
    chk("t2_rv_c6",   64'(rv_hist[6]), 64'hF);
    do_reset();

    // Sink backpressure for 3 cycles while row 2 is presented.
    run_job(8, -1, -1, 18, 20, -1, -1, -1);
    chk("t3_stall",   m_stall,   mask(18, 20));
    chk("t3_flush",   m_flush,   mask(16, 22));
    chk("t3_done",    m_done,    mask(23, 23));
    chk("t3_row_c20", 64'(or_hist[20]), 64'd2);
    chk("t3_row_c21", 64'(or_hist[21]), 64'd2);
    chk("t3_row_c22", 64'(or_hist[22]), 64'd3);
    chk("t3_rows",    64'(acc_seq), 64'hE4);
    do_reset();

    // Zero-length job.
    run_job(0, -1, -1, -1, -1, -1, -1, -1);
    chk("t4_done",    m_done,    mask(1, 1));
    chk("t4_busy",    m_busy,    64'h0);
    chk("t4_compute", m_compute, 64'h0);
    chk("t4_flush",   m_flush,   64'h0);
    do_reset();

    // Reset mid-RUN at cycle 10, fresh job at 12.
    run_job(8, -1, -1, -1, -1, 10, 12, -1);
    chk("t5_outs_c11", 64'(outs_hist[11]), 64'h0);
    chk("t5_done",     m_done,    mask(32, 32));
    chk("t5_compute",  m_compute, mask(1, 10) | mask(13, 27));
    chk("t5_flush",    m_flush,   mask(28, 31));
    do_reset();

    // START held high through the first job and into the second.
    run_job(8, -1, -1, -1, -1, -1, -1, 25);
    chk("t6_done",    m_done,    mask(20, 20) | mask(41, 41));
    chk("t6_busy",    m_busy,    mask(1, 19) | mask(22, 40));
    chk("t6_compute", m_compute, mask(1, 15) | mask(22, 36));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
